twin_stick_mapper: RTL and testbench

TWIN_STICK_MAPPER -- requirements
Module: twin_stick_mapper

---
 rtl/twin_stick_mapper.sv | 207 ++++++++++++++++++++
 tb/tb_twin_stick_mapper.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twin_stick_mapper.sv
// Twin-stick mapper: analog sticks with hysteresis to diagonal run/aim buttons, plus an aim-fire trigger FSM.
// Optional autofire pulsing of the trigger in FIRE is enabled by defining TWIN_STICK_AUTOFIRE_EN.
module twin_stick_mapper #(
   parameter int NUM_PLAYERS  = 2,
   parameter int THRESH       = 20,
   parameter int HYST         = 4,
   parameter int FIRE_HOLD    = 3,
   parameter int AUTOFIRE_DIV = 4
) (
   input  logic                       clk_sys,
   input  logic                       reset_n,
   input  logic                       ce,
   input  logic [32*NUM_PLAYERS-1:0]  joystick,
   input  logic [16*NUM_PLAYERS-1:0]  analog_l,
   input  logic [16*NUM_PLAYERS-1:0]  analog_r,
   input  logic                       aimfire_en,
   output logic [4*NUM_PLAYERS-1:0]   btn_run,
   output logic [4*NUM_PLAYERS-1:0]   btn_aim,
   output logic [NUM_PLAYERS-1:0]     btn_trigger,
   output logic [NUM_PLAYERS-1:0]     btn_start,
   output logic                       btn_coin
);

   typedef enum logic [1:0] {AX_NEUTRAL = 2'd0, AX_NEG = 2'd1, AX_POS = 2'd2} axis_t;
   typedef enum logic [1:0] {F_IDLE = 2'd0, F_FIRE = 2'd1, F_HOLD = 2'd2} fire_t;

   localparam logic signed [8:0] POS_ON  = 9'(THRESH);
   localparam logic signed [8:0] NEG_ON  = -POS_ON;
   localparam logic signed [8:0] POS_OFF = 9'(THRESH - HYST);
   localparam logic signed [8:0] NEG_OFF = -POS_OFF;

   // Sign-extend to 9 bits so that -128 compares as a full negative deflection.
   function automatic axis_t axis_next(input axis_t s, input logic [7:0] raw);
      logic signed [8:0] v;
      axis_t n;
      v = {raw[7], raw};
      n = s;
      case (s)
         AX_NEUTRAL: if (v > POS_ON) n = AX_POS; else if (v < NEG_ON) n = AX_NEG;
         AX_POS:     if (v <= POS_OFF) n = AX_NEUTRAL;
         AX_NEG:     if (v >= NEG_OFF) n = AX_NEUTRAL;
         default:    n = AX_NEUTRAL;
      endcase
      return n;
   endfunction

   // {up, down, left, right}; negative Y is up.
   function automatic logic [3:0] dir_mask(input axis_t y, input axis_t x);
      return {y == AX_NEG, y == AX_POS, x == AX_NEG, x == AX_POS};
   endfunction

   function automatic logic [3:0] diag(input logic [3:0] m);
      return {m[3] & m[0], m[2] & m[1], m[3] & m[1], m[2] & m[0]};
   endfunction

   function automatic logic [3:0] reorder(input logic [3:0] r);
      return {r[2], r[0], r[1], r[3]};
   endfunction

   axis_t                    ax_q [NUM_PLAYERS][4];
   axis_t                    ax_d [NUM_PLAYERS][4];
   fire_t                    fs_q [NUM_PLAYERS];
   fire_t                    fs_d [NUM_PLAYERS];
   logic [3:0]               hold_q [NUM_PLAYERS];
   logic [3:0]               hold_d [NUM_PLAYERS];
   logic [3:0]               l_mask [NUM_PLAYERS];
   logic [3:0]               r_mask [NUM_PLAYERS];
   logic [3:0]               run_raw [NUM_PLAYERS];
   logic [3:0]               aim_raw [NUM_PLAYERS];
   logic                     fire_level [NUM_PLAYERS];
   logic [4*NUM_PLAYERS-1:0] run_q, run_d, aim_q, aim_d;
   logic [NUM_PLAYERS-1:0]   trig_q, trig_d, start_q, start_d;
   logic                     coin_q, coin_d;
   logic                     unused_bits;
`ifdef TWIN_STICK_AUTOFIRE_EN
   logic [3:0]               af_cnt_q [NUM_PLAYERS];
   logic [3:0]               af_cnt_d [NUM_PLAYERS];
   logic                     af_ph_q [NUM_PLAYERS];
   logic                     af_ph_d [NUM_PLAYERS];
`endif

   always_comb begin
      run_d       = '0;
      aim_d       = '0;
      start_d     = '0;
      coin_d      = 1'b0;
      unused_bits = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         ax_d[p][0]  = axis_next(ax_q[p][0], analog_l[p*16 +: 8]);
         ax_d[p][1]  = axis_next(ax_q[p][1], analog_l[p*16+8 +: 8]);
         ax_d[p][2]  = axis_next(ax_q[p][2], analog_r[p*16 +: 8]);
         ax_d[p][3]  = axis_next(ax_q[p][3], analog_r[p*16+8 +: 8]);
         l_mask[p]   = dir_mask(ax_q[p][1], ax_q[p][0]);
         r_mask[p]   = dir_mask(ax_q[p][3], ax_q[p][2]);
         // Any left-stick deflection overrides the pad, even when it is not a diagonal.
         run_raw[p]  = (l_mask[p] != 4'd0) ? diag(l_mask[p]) : joystick[p*32 +: 4];
         aim_raw[p]  = diag(r_mask[p]) | {joystick[p*32+7], joystick[p*32+8],
                                          joystick[p*32+9], joystick[p*32+10]};
         run_d[p*4 +: 4] = reorder(run_raw[p]);
         aim_d[p*4 +: 4] = reorder(aim_raw[p]);
         start_d[p]  = joystick[p*32+5];
         coin_d      = coin_d | joystick[p*32+6];
         unused_bits = unused_bits ^ (^joystick[p*32+11 +: 21]);
      end
   end

   always_comb begin
      trig_d = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         fs_d[p]   = fs_q[p];
         hold_d[p] = hold_q[p];
         if (!aimfire_en) begin
            fs_d[p]   = F_IDLE;
            hold_d[p] = 4'd0;
         end else begin
            case (fs_q[p])
               F_IDLE: if (|aim_raw[p]) fs_d[p] = F_FIRE;
               F_FIRE: begin
                  // A release always loads the full hold count, regardless of ce.
                  if (!(|aim_raw[p])) begin
                     if (FIRE_HOLD == 0) fs_d[p] = F_IDLE;
                     else begin
                        fs_d[p]   = F_HOLD;
                        hold_d[p] = 4'(FIRE_HOLD);
                     end
                  end
               end
               F_HOLD: begin
                  if (|aim_raw[p]) begin
                     fs_d[p]   = F_FIRE;
                     hold_d[p] = 4'd0;
                  end else if (ce) begin
                     if (hold_q[p] <= 4'd1) begin
                        fs_d[p]   = F_IDLE;
                        hold_d[p] = 4'd0;
                     end else begin
                        hold_d[p] = hold_q[p] - 4'd1;
                     end
                  end
               end
               default: fs_d[p] = F_IDLE;
            endcase
         end
`ifdef TWIN_STICK_AUTOFIRE_EN
         af_cnt_d[p] = af_cnt_q[p];
         af_ph_d[p]  = af_ph_q[p];
         if (fs_d[p] == F_FIRE && fs_q[p] != F_FIRE) begin
            af_cnt_d[p] = 4'd0;
            af_ph_d[p]  = 1'b1;
         end else if (fs_d[p] == F_FIRE && ce) begin
            if (af_cnt_q[p] == 4'(AUTOFIRE_DIV - 1)) begin
               af_cnt_d[p] = 4'd0;
               af_ph_d[p]  = ~af_ph_q[p];
            end else begin
               af_cnt_d[p] = af_cnt_q[p] + 4'd1;
            end
         end
         fire_level[p] = af_ph_d[p];
`else
         fire_level[p] = 1'b1;
`endif
         trig_d[p] = joystick[p*32+4] | (fs_d[p] == F_HOLD) |
                     ((fs_d[p] == F_FIRE) & fire_level[p]);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int a = 0; a < 4; a++) ax_q[p][a] <= AX_NEUTRAL;
            fs_q[p]     <= F_IDLE;
            hold_q[p]   <= 4'd0;
`ifdef TWIN_STICK_AUTOFIRE_EN
            af_cnt_q[p] <= 4'd0;
            af_ph_q[p]  <= 1'b0;
`endif
         end
         run_q   <= '0;
         aim_q   <= '0;
         trig_q  <= '0;
         start_q <= '0;
         coin_q  <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int a = 0; a < 4; a++) ax_q[p][a] <= ax_d[p][a];
            fs_q[p]     <= fs_d[p];
            hold_q[p]   <= hold_d[p];
`ifdef TWIN_STICK_AUTOFIRE_EN
            af_cnt_q[p] <= af_cnt_d[p];
            af_ph_q[p]  <= af_ph_d[p];
`endif
         end
         run_q   <= run_d;
         aim_q   <= aim_d;
         trig_q  <= trig_d;
         start_q <= start_d;
         coin_q  <= coin_d;
      end
   end

   assign btn_run     = run_q;
   assign btn_aim     = aim_q;
   assign btn_trigger = trig_q;
   assign btn_start   = start_q;
   assign btn_coin    = coin_q;

endmodule

// File: tb/tb_twin_stick_mapper.sv
// Bench for twin_stick_mapper: directed scenarios plus randomized traffic against a cycle model
// built from direction sets and integer fire modes.
module tb_twin_stick_mapper;

   localparam int NP  = 2;
   localparam int T   = 20;
   localparam int H   = 4;
   localparam int FH  = 3;
   localparam int DIV = 4;

   logic            clk_sys;
   logic            reset_n;
   logic            ce;
   logic [32*NP-1:0] joystick;
   logic [16*NP-1:0] analog_l, analog_r;
   logic            aimfire_en;
   logic [4*NP-1:0] btn_run, btn_aim;
   logic [NP-1:0]   btn_trigger, btn_start;
   logic            btn_coin;

   int checks = 0;
   int errors = 0;

   twin_stick_mapper #(.NUM_PLAYERS(NP), .THRESH(T), .HYST(H), .FIRE_HOLD(FH), .AUTOFIRE_DIV(DIV)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .joystick(joystick),
      .analog_l(analog_l), .analog_r(analog_r), .aimfire_en(aimfire_en),
      .btn_run(btn_run), .btn_aim(btn_aim), .btn_trigger(btn_trigger),
      .btn_start(btn_start), .btn_coin(btn_coin)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Reference state: axis position -1/0/+1, fire mode 0 idle / 1 firing / 2 lingering.
   int ax [NP][4];
   int mode [NP], hcnt [NP], aph [NP], atick [NP];
   logic [4*NP-1:0] e_run, e_aim;
   logic [NP-1:0]   e_trig, e_start;
   logic            e_coin;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sval(input logic [7:0] b);
      return int'($signed(b));
   endfunction

   function automatic int axis_step(input int s, input int v);
      if (s == 0) return (v > T) ? 1 : ((v < -T) ? -1 : 0);
      if (s == 1) return (v <= T - H) ? 0 : 1;
      return (v >= -(T - H)) ? 0 : -1;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         for (int a = 0; a < 4; a++) ax[p][a] = 0;
         mode[p] = 0; hcnt[p] = 0; aph[p] = 0; atick[p] = 0;
      end
      e_run = '0; e_aim = '0; e_trig = '0; e_start = '0; e_coin = 1'b0;
   endtask

   task automatic model_update();
      logic [31:0] j;
      logic up, dn, lf, rt, ur, ul, dr, dl, aur, aul, adr, adl, aim_any, lvl;
      int old;
      e_coin = 1'b0;
      for (int p = 0; p < NP; p++) begin
         j  = joystick[p*32 +: 32];
         up = (ax[p][1] == -1); dn = (ax[p][1] == 1); lf = (ax[p][0] == -1); rt = (ax[p][0] == 1);
         if (up || dn || lf || rt) begin
            ur = up & rt; ul = up & lf; dr = dn & rt; dl = dn & lf;
         end else begin
            ur = j[3]; dl = j[2]; ul = j[1]; dr = j[0];
         end
         e_run[p*4 +: 4] = {dl, dr, ul, ur};
         up = (ax[p][3] == -1); dn = (ax[p][3] == 1); lf = (ax[p][2] == -1); rt = (ax[p][2] == 1);
         aur = (up & rt) | j[7]; adl = (dn & lf) | j[8]; aul = (up & lf) | j[9]; adr = (dn & rt) | j[10];
         e_aim[p*4 +: 4] = {adl, adr, aul, aur};
         aim_any = aur | adl | aul | adr;
         e_start[p] = j[5];
         e_coin = e_coin | j[6];
         old = mode[p];
         if (!aimfire_en) begin
            mode[p] = 0; hcnt[p] = 0;
         end else if (old == 0) begin
            if (aim_any) mode[p] = 1;
         end else if (old == 1) begin
            if (!aim_any) begin
               if (FH == 0) mode[p] = 0;
               else begin mode[p] = 2; hcnt[p] = FH; end
            end
         end else begin
            if (aim_any) mode[p] = 1;
            else if (ce) begin
               hcnt[p]--;
               if (hcnt[p] == 0) mode[p] = 0;
            end
         end
         if (mode[p] == 1 && old != 1) begin
            aph[p] = 1; atick[p] = 0;
         end else if (mode[p] == 1 && ce) begin
            atick[p]++;
            if (atick[p] == DIV) begin atick[p] = 0; aph[p] = 1 - aph[p]; end
         end
`ifdef TWIN_STICK_AUTOFIRE_EN
         lvl = (aph[p] != 0);
`else
         lvl = 1'b1;
`endif
         e_trig[p] = j[4] | (mode[p] == 2) | ((mode[p] == 1) & lvl);
         ax[p][0] = axis_step(ax[p][0], sval(analog_l[p*16 +: 8]));
         ax[p][1] = axis_step(ax[p][1], sval(analog_l[p*16+8 +: 8]));
         ax[p][2] = axis_step(ax[p][2], sval(analog_r[p*16 +: 8]));
         ax[p][3] = axis_step(ax[p][3], sval(analog_r[p*16+8 +: 8]));
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_run"},   32'(btn_run),     32'(e_run));
      chk({tag, "_aim"},   32'(btn_aim),     32'(e_aim));
      chk({tag, "_trig"},  32'(btn_trigger), 32'(e_trig));
      chk({tag, "_start"}, 32'(btn_start),   32'(e_start));
      chk({tag, "_coin"},  32'(btn_coin),    32'(e_coin));
   endtask

   task automatic step(input string tag);
      model_update();
      @(posedge clk_sys);
      #1;
      check_all(tag);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_run"},   32'(btn_run),     32'd0);
      chk({tag, "_aim"},   32'(btn_aim),     32'd0);
      chk({tag, "_trig"},  32'(btn_trigger), 32'd0);
      chk({tag, "_start"}, 32'(btn_start),   32'd0);
      chk({tag, "_coin"},  32'(btn_coin),    32'd0);
   endtask

   function automatic logic [7:0] rand_axis(input logic [7:0] prev);
      int v;
      case ($urandom_range(0, 5))
         0: v = int'($urandom_range(0, 255)) - 128;
         1: v = int'($urandom_range(14, 24));
         2: v = -int'($urandom_range(14, 24));
         3: v = 0;
         default: return prev;
      endcase
      return 8'(v);
   endfunction

   initial begin
      reset_n = 1'b0; ce = 1'b0; joystick = '0; analog_l = '0; analog_r = '0; aimfire_en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_sys);
      #1;
      check_zero("reset");
      joystick[6] = 1'b1;
      joystick[5] = 1'b1;
      @(posedge clk_sys);
      #1;
      check_zero("reset_hold");
      joystick = '0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      step("idle");

      // Left stick up-right, then hysteresis on X.
      analog_l[15:8] = 8'hD8;
      analog_l[7:0]  = 8'h28;
      step("l_diag_a");
      step("l_diag_b");
      chk("l_diag_run", 32'(btn_run[3:0]), 32'h1);
      analog_l[7:0] = 8'h12;
      step("l_hyst_a");
      step("l_hyst_b");
      chk("l_hyst_run", 32'(btn_run[3:0]), 32'h1);
      analog_l[7:0] = 8'h0F;
      step("l_rel_a");
      step("l_rel_b");
      chk("l_rel_run", 32'(btn_run[3:0]), 32'h0);

      // Pad passthrough, then analog override with no diagonal.
      analog_l = '0;
      joystick[3:0] = 4'b0101;
      repeat (3) step("pad");
      analog_l[7:0] = 8'd30;
      step("ovr_a");
      step("ovr_b");
      chk("ovr_run", 32'(btn_run[3:0]), 32'h0);
      analog_l = '0;
      joystick = '0;
      repeat (2) step("clr");

      // Aim-fire with hold after release; release coincides with ce.
      aimfire_en = 1'b1;
      joystick[7] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ce = (i % 2 == 1);
         step("fire");
      end
      joystick[7] = 1'b0;
      ce = 1'b1;
      step("rel");
      chk("hold_entry_trig", 32'(btn_trigger[0]), 32'h1);
      for (int i = 0; i < 5; i++) begin
         ce = (i % 2 == 0);
         step("hold");
         if (i < 4) chk("hold_trig", 32'(btn_trigger[0]), 32'h1);
      end
      chk("hold_end_trig", 32'(btn_trigger[0]), 32'h0);
      ce = 1'b0;

      // Aim-fire disabled: aim still maps, trigger follows the pad bit only.
      aimfire_en = 1'b0;
      joystick[7] = 1'b1;
      step("dis_a");
      step("dis_b");
      chk("dis_trig", 32'(btn_trigger[0]), 32'h0);
      chk("dis_aim0", 32'(btn_aim[0]), 32'h1);

      // Dropping aimfire_en mid-hold.
      aimfire_en = 1'b1;
      step("re_en");
      joystick[7] = 1'b0;
      step("re_rel");
      aimfire_en = 1'b0;
      step("drop_en");
      chk("drop_en_trig", 32'(btn_trigger[0]), 32'h0);

      // Reset asserted mid-hold with coin held.
      aimfire_en = 1'b1;
      joystick[7] = 1'b1;
      step("r_fire");
      joystick[7] = 1'b0;
      joystick[6] = 1'b1;
      step("r_hold");
      chk("r_hold_trig", 32'(btn_trigger[0]), 32'h1);
      #1;
      reset_n = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      @(posedge clk_sys);
      #1;
      check_zero("async_rst_hold");
      @(negedge clk_sys);
      reset_n = 1'b1;
      step("post_rst");
      chk("post_rst_coin", 32'(btn_coin), 32'h1);
      chk("post_rst_trig", 32'(btn_trigger), 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 2 * NP; k++) begin
            analog_l[k*8 +: 8] = rand_axis(analog_l[k*8 +: 8]);
            analog_r[k*8 +: 8] = rand_axis(analog_r[k*8 +: 8]);
         end
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 5) == 0) joystick[p*32 +: 32] = $urandom & 32'hFFFF_FFFF;
         ce = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) aimfire_en = ~aimfire_en;
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
